relu_pool_l2: RTL and testbench

RELU_POOL_L2 -- requirements
Module: relu_pool_l2

---
 rtl/relu_pool_l2_pkg.sv | 23 ++
 rtl/relu_pool_l2_pool_max2.sv | 24 ++
 rtl/relu_pool_l2.sv | 164 ++++++++++++++++
 tb/tb_relu_pool_l2.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_pool_l2_pkg.sv
// Shared CNN package: activation width, beat geometry, pooling state
// encodings and the ReLU / unsigned-max helpers used by the layer stages.
package relu_pool_l2_pkg;

  localparam int CNN_DW  = 16;
  localparam int LANES   = 4;
  localparam int KERNELS = 8;

  localparam logic [0:0] ST_EVEN = 1'b0;
  localparam logic [0:0] ST_ODD  = 1'b1;

  // Negative two's-complement values clamp to zero.
  function automatic logic [CNN_DW-1:0] relu(input logic [CNN_DW-1:0] x);
    return x[CNN_DW-1] ? '0 : x;
  endfunction

  // Unsigned maximum; operands are non-negative once ReLU has run.
  function automatic logic [CNN_DW-1:0] umax(input logic [CNN_DW-1:0] a,
                                             input logic [CNN_DW-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_pool_l2_pool_max2.sv
// Combinational ReLU followed by a 2-input unsigned maximum on one lane pair.
module pool_max2
  import relu_pool_l2_pkg::*;
#(
  parameter int DW = CNN_DW
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] max_o
);

  generate
    if (DW == CNN_DW) begin : gPkg
      assign max_o = umax(relu(a_i), relu(b_i));
    end else begin : gGeneric
      logic [DW-1:0] aRelu;
      logic [DW-1:0] bRelu;
      assign aRelu = a_i[DW-1] ? '0 : a_i;
      assign bRelu = b_i[DW-1] ? '0 : b_i;
      assign max_o = (aRelu >= bRelu) ? aRelu : bRelu;
    end
  endgenerate

endmodule

// File: rtl/relu_pool_l2.sv
// 2x2 max-pool with ReLU over 8 kernel streams. Even rows are pooled
// horizontally into a row buffer; odd rows combine with that buffer and
// emit one pooled beat per accepted input beat through a single output
// register with valid/ready handshake.
module relu_pool_l2
  import relu_pool_l2_pkg::*;
#(
  parameter int DW        = CNN_DW,
  parameter int ROW_BEATS = 7,
  parameter int ROWS      = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [4*DW-1:0]   i_data_0,
  input  logic [4*DW-1:0]   i_data_1,
  input  logic [4*DW-1:0]   i_data_2,
  input  logic [4*DW-1:0]   i_data_3,
  input  logic [4*DW-1:0]   i_data_4,
  input  logic [4*DW-1:0]   i_data_5,
  input  logic [4*DW-1:0]   i_data_6,
  input  logic [4*DW-1:0]   i_data_7,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [2*DW-1:0]   o_data_0,
  output logic [2*DW-1:0]   o_data_1,
  output logic [2*DW-1:0]   o_data_2,
  output logic [2*DW-1:0]   o_data_3,
  output logic [2*DW-1:0]   o_data_4,
  output logic [2*DW-1:0]   o_data_5,
  output logic [2*DW-1:0]   o_data_6,
  output logic [2*DW-1:0]   o_data_7,
  output logic              o_last
);

  localparam int EW = 2 * DW * KERNELS;
  localparam int CW = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [LANES*DW-1:0] inData [KERNELS];
  logic [EW-1:0]       hWord;
  logic [EW-1:0]       vWord;
  logic [EW-1:0]       bufWord;
  logic [EW-1:0]       rowBuf [ROW_BEATS];

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          oValid_q, oValid_d;
  logic          oLast_q, oLast_d;
  logic [EW-1:0] oData_q, oData_d;

  logic accept;
  logic colEnd;
  logic rowEnd;

  assign inData[0] = i_data_0;
  assign inData[1] = i_data_1;
  assign inData[2] = i_data_2;
  assign inData[3] = i_data_3;
  assign inData[4] = i_data_4;
  assign inData[5] = i_data_5;
  assign inData[6] = i_data_6;
  assign inData[7] = i_data_7;

  assign i_ready = (state_q == ST_EVEN) || !oValid_q || o_ready;
  assign accept  = i_valid && i_ready;
  assign colEnd  = (col_q == CW'(ROW_BEATS - 1));
  assign rowEnd  = (row_q == RW'(ROWS - 1));

  // Only odd rows consult the buffer; even rows see a zero word.
  assign bufWord = (state_q == ST_ODD) ? rowBuf[col_q] : '0;

  // Horizontal pool of each lane pair, then vertical max against the buffer.
  generate
    for (genvar k = 0; k < KERNELS; k++) begin : gKernel
      for (genvar p = 0; p < LANES / 2; p++) begin : gPair
        pool_max2 #(.DW(DW)) uHorz (
          .a_i   (inData[k][(2*p)*DW +: DW]),
          .b_i   (inData[k][(2*p+1)*DW +: DW]),
          .max_o (hWord[(2*k+p)*DW +: DW])
        );
        pool_max2 #(.DW(DW)) uVert (
          .a_i   (bufWord[(2*k+p)*DW +: DW]),
          .b_i   (hWord[(2*k+p)*DW +: DW]),
          .max_o (vWord[(2*k+p)*DW +: DW])
        );
      end
    end
  endgenerate

  // Row buffer: plain register array, written only on even-row beats.
  always_ff @(posedge clk) begin
    if (accept && (state_q == ST_EVEN)) begin
      rowBuf[col_q] <= hWord;
    end
  end

  // Position tracking and output-register next state.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    oValid_d = oValid_q;
    oLast_d  = oLast_q;
    oData_d  = oData_q;

    if (accept) begin
      if (colEnd) begin
        col_d = '0;
        if (rowEnd) begin
          row_d   = '0;
          state_d = ST_EVEN;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = ~state_q;
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (accept && (state_q == ST_ODD)) begin
      oValid_d = 1'b1;
      oData_d  = vWord;
      oLast_d  = rowEnd && colEnd;
    end else if (o_ready) begin
      oValid_d = 1'b0;
      oLast_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EVEN;
      col_q    <= '0;
      row_q    <= '0;
      oValid_q <= 1'b0;
      oLast_q  <= 1'b0;
      oData_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      oValid_q <= oValid_d;
      oLast_q  <= oLast_d;
      oData_q  <= oData_d;
    end
  end

  assign o_valid  = oValid_q;
  assign o_last   = oLast_q;
  assign o_data_0 = oData_q[0*2*DW +: 2*DW];
  assign o_data_1 = oData_q[1*2*DW +: 2*DW];
  assign o_data_2 = oData_q[2*2*DW +: 2*DW];
  assign o_data_3 = oData_q[3*2*DW +: 2*DW];
  assign o_data_4 = oData_q[4*2*DW +: 2*DW];
  assign o_data_5 = oData_q[5*2*DW +: 2*DW];
  assign o_data_6 = oData_q[6*2*DW +: 2*DW];
  assign o_data_7 = oData_q[7*2*DW +: 2*DW];

endmodule

// File: tb/tb_relu_pool_l2.sv
// Scoreboard bench for relu_pool_l2: the stimulus side pushes hand-derived
// expected pooled beats, an independent monitor pops them on each transfer.
module tb_relu_pool_l2;

  localparam int DW = 16;
  localparam int RB = 7;
  localparam int NR = 28;

  typedef logic [7:0][4*DW-1:0] in_t;
  typedef logic [7:0][2*DW-1:0] out_t;
  typedef struct packed {
    out_t data;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid;
  logic i_ready;
  logic o_valid;
  logic o_ready;
  logic o_last;
  in_t  iData;
  logic [2*DW-1:0] o_data_0, o_data_1, o_data_2, o_data_3;
  logic [2*DW-1:0] o_data_4, o_data_5, o_data_6, o_data_7;
  out_t oBus;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;
  int   outCount = 0;
  logic held = 1'b0;
  exp_t heldVal;

  always #5 clk = ~clk;

  assign oBus = {o_data_7, o_data_6, o_data_5, o_data_4,
                 o_data_3, o_data_2, o_data_1, o_data_0};

  relu_pool_l2 #(.DW(DW), .ROW_BEATS(RB), .ROWS(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_data_0 (iData[0]),
    .i_data_1 (iData[1]),
    .i_data_2 (iData[2]),
    .i_data_3 (iData[3]),
    .i_data_4 (iData[4]),
    .i_data_5 (iData[5]),
    .i_data_6 (iData[6]),
    .i_data_7 (iData[7]),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data_0 (o_data_0),
    .o_data_1 (o_data_1),
    .o_data_2 (o_data_2),
    .o_data_3 (o_data_3),
    .o_data_4 (o_data_4),
    .o_data_5 (o_data_5),
    .o_data_6 (o_data_6),
    .o_data_7 (o_data_7),
    .o_last   (o_last)
  );

  task automatic checkOutput(input string name, input logic [511:0] act,
                             input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic in_t fillIn(input int v);
    logic [DW-1:0] lane;
    lane = DW'(v);
    return {32{lane}};
  endfunction

  function automatic out_t fillOut(input int v);
    logic [DW-1:0] lane;
    lane = DW'(v);
    return {16{lane}};
  endfunction

  task automatic pushExp(input out_t d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    sbQ.push_back(e);
  endtask

  // Hold one beat on the inputs until accepted; optional idle cycle after.
  task automatic applyStimulus(input in_t d, input bit gap);
    int  budget;
    bit  acc;
    budget  = 0;
    acc     = 1'b0;
    iData   = d;
    i_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got no i_ready, required acceptance");
        acc = 1'b1;
      end
    end
    i_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Beats carry row*16+col in every lane; odd rows expect the same formula.
  task automatic sendBeats(input bit gap, input int nBeats);
    int r;
    int c;
    for (int b = 0; b < nBeats; b++) begin
      r = (b / RB) % NR;
      c = b % RB;
      if (r % 2 == 1) pushExp(fillOut(r * 16 + c), (r == NR - 1) && (c == RB - 1));
      applyStimulus(fillIn(r * 16 + c), gap);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", 512'(sbQ.size()), 512'(0));
  endtask

  task automatic pulseReset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    checkOutput("reset_ovalid", 512'(o_valid), 512'(0));
    checkOutput("reset_iready", 512'(i_ready), 512'(1));
    sbQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare each transferred beat and watch held beats for stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checkOutput("hold_valid", 512'(o_valid), 512'(1));
        checkOutput("hold_data", 512'({oBus, o_last}), 512'(heldVal));
      end
      held = 1'b0;
      if (o_valid && !o_ready) begin
        held    = 1'b1;
        heldVal = {oBus, o_last};
      end
      if (o_valid && o_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %0h, required none", oBus);
        end else begin
          e = sbQ.pop_front();
          checkOutput("out_beat", 512'({oBus, o_last}), 512'(e));
          outCount++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_t  a;
    out_t z;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    iData   = '0;
    #2;
    checkOutput("rst_iready", 512'(i_ready), 512'(1));
    checkOutput("rst_ovalid", 512'(o_valid), 512'(0));
    checkOutput("rst_olast", 512'(o_last), 512'(0));
    checkOutput("rst_odata", 512'(oBus), 512'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Hand vector: row 0 lanes 5,-16,3,7; row 1 lanes 1,2,0x8000,4 -> 5,7.
    a = {8{16'h0007, 16'h0003, 16'hFFF0, 16'h0005}};
    applyStimulus(a, 1'b0);
    for (int c = 1; c < RB; c++) applyStimulus('0, 1'b0);
    a = {8{16'h0004, 16'h8000, 16'h0002, 16'h0001}};
    z = {8{16'h0007, 16'h0005}};
    pushExp(z, 1'b0);
    applyStimulus(a, 1'b0);
    for (int c = 1; c < RB; c++) begin
      pushExp('0, 1'b0);
      applyStimulus('0, 1'b0);
    end
    drain();
    pulseReset();

    // Continuous full frame.
    outCount = 0;
    sendBeats(1'b0, 2 * RB * (NR / 2));
    drain();
    checkOutput("frame_count", 512'(outCount), 512'(98));

    // Full frame with a 5-cycle downstream stall on the first odd row.
    outCount = 0;
    fork
      sendBeats(1'b0, 2 * RB * (NR / 2));
      begin
        int n;
        n = 0;
        while (!o_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        checkOutput("stall_seen_valid", 512'(o_valid), 512'(1));
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_iready", 512'(i_ready), 512'(0));
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    drain();
    checkOutput("stall_count", 512'(outCount), 512'(98));

    // Input valid every other cycle.
    outCount = 0;
    sendBeats(1'b1, 2 * RB * (NR / 2));
    drain();
    checkOutput("gap_count", 512'(outCount), 512'(98));

    // Reset two beats into row 3, then a clean frame.
    sendBeats(1'b0, 3 * RB + 2);
    pulseReset();
    checkOutput("midrst_olast", 512'(o_last), 512'(0));
    outCount = 0;
    sendBeats(1'b0, 2 * RB * (NR / 2));
    drain();
    checkOutput("midrst_count", 512'(outCount), 512'(98));

    // All-negative lanes pool to zero.
    a = {8{16'h8000, 16'hFFFF, 16'h8123, 16'hC000}};
    for (int c = 0; c < RB; c++) applyStimulus(a, 1'b0);
    for (int c = 0; c < RB; c++) begin
      pushExp('0, 1'b0);
      applyStimulus(a, 1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
